cplx_alu_sched: RTL and testbench

Sequencing controller for the team's real/complex arithmetic unit. It accepts one operation at a time over a valid/ready handshake, latches the operands, and steps a single shared 16x16 signed multiplier over as many cycles as the operation needs. Complex multiplication takes four products; every other operation takes one cycle. The block sits between the operand source and the result consumer, and replaces the previous free-running, chooser-driven combinational evaluation.

---
 rtl/cplx_alu_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_cplx_alu_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cplx_alu_sched.sv
// Sequencer for the real/complex ALU: accepts one op over valid/ready, steps a single
// shared signed multiplier (four steps for complex mul), and holds the result until taken.
module cplx_alu_sched #(
    parameter int W  = 16,
    parameter int RW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic          is_complex,
    input  logic [W-1:0]  a_re,
    input  logic [W-1:0]  a_im,
    input  logic [W-1:0]  b_re,
    input  logic [W-1:0]  b_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] y_re,
    output logic [RW-1:0] y_im,
    output logic          out_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t                state_q, state_d;
    logic [1:0]            step_q, step_d;
    logic [1:0]            op_q, op_d;
    logic                  cplx_q, cplx_d;
    logic signed [W-1:0]   ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic signed [RW-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [RW-1:0]  y_re_q, y_re_d, y_im_q, y_im_d;
    logic                  err_q, err_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic signed [W-1:0]   mul_a_s, mul_b_s;
    logic signed [RW-1:0]  prod_s;
    logic signed [RW-1:0]  acc_re_nx_s, acc_im_nx_s;
    logic signed [RW-1:0]  res_re_s, res_im_s;
    logic                  res_err_s;
    logic                  cmul_s;
    logic                  last_s;

    assign cmul_s = (op_q == OP_MUL) && cplx_q;
    assign prod_s = RW'(mul_a_s) * RW'(mul_b_s);

    // Operand mux for the one shared multiplier; step 0 also serves real mul.
    always_comb begin
        mul_a_s = ar_q;
        mul_b_s = br_q;
        case (step_q)
            2'd0: begin mul_a_s = ar_q; mul_b_s = br_q; end
            2'd1: begin mul_a_s = ai_q; mul_b_s = bi_q; end
            2'd2: begin mul_a_s = ar_q; mul_b_s = bi_q; end
            2'd3: begin mul_a_s = ai_q; mul_b_s = br_q; end
            default: begin mul_a_s = ar_q; mul_b_s = br_q; end
        endcase
    end

    // Accumulator update for the current complex-mul step and the step-closing flag.
    always_comb begin
        acc_re_nx_s = acc_re_q;
        acc_im_nx_s = acc_im_q;
        last_s      = 1'b1;
        case (step_q)
            2'd0:    acc_re_nx_s = acc_re_q + prod_s;
            2'd1:    acc_re_nx_s = acc_re_q - prod_s;
            2'd2:    acc_im_nx_s = acc_im_q + prod_s;
            2'd3:    acc_im_nx_s = acc_im_q + prod_s;
            default: acc_re_nx_s = acc_re_q;
        endcase
        if (cmul_s) begin
            last_s = (step_q == 2'd3);
        end else begin
            last_s = 1'b1;
        end
    end

    // Final result selection; imaginary parts are zero for real operands.
    always_comb begin
        res_re_s  = '0;
        res_im_s  = '0;
        res_err_s = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_re_s = RW'(ar_q) + RW'(br_q);
                if (cplx_q) begin
                    res_im_s = RW'(ai_q) + RW'(bi_q);
                end else begin
                    res_im_s = '0;
                end
            end
            OP_SUB: begin
                res_re_s = RW'(ar_q) - RW'(br_q);
                if (cplx_q) begin
                    res_im_s = RW'(ai_q) - RW'(bi_q);
                end else begin
                    res_im_s = '0;
                end
            end
            OP_MUL: begin
                if (cplx_q) begin
                    res_re_s = acc_re_nx_s;
                    res_im_s = acc_im_nx_s;
                end else begin
                    res_re_s = prod_s;
                    res_im_s = '0;
                end
            end
            default: begin
                res_re_s  = '0;
                res_im_s  = '0;
                res_err_s = 1'b1;
            end
        endcase
    end

    // Next-state logic for the IDLE -> EXEC -> DONE handshake sequencer.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        op_d        = op_q;
        cplx_d      = cplx_q;
        ar_d        = ar_q;
        ai_d        = ai_q;
        br_d        = br_q;
        bi_d        = bi_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        y_re_d      = y_re_q;
        y_im_d      = y_im_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = op;
                    cplx_d     = is_complex;
                    ar_d       = a_re;
                    ai_d       = a_im;
                    br_d       = b_re;
                    bi_d       = b_im;
                    acc_re_d   = '0;
                    acc_im_d   = '0;
                    step_d     = 2'd0;
                    in_ready_d = 1'b0;
                    state_d    = ST_EXEC;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cmul_s) begin
                    acc_re_d = acc_re_nx_s;
                    acc_im_d = acc_im_nx_s;
                end else begin
                    acc_re_d = acc_re_q;
                end
                if (last_s) begin
                    y_re_d      = res_re_s;
                    y_im_d      = res_im_s;
                    err_d       = res_err_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset discards any op in flight and clears the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 2'd0;
            op_q        <= 2'b00;
            cplx_q      <= 1'b0;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            op_q        <= op_d;
            cplx_q      <= cplx_d;
            ar_q        <= ar_d;
            ai_q        <= ai_d;
            br_q        <= br_d;
            bi_q        <= bi_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_cplx_alu_sched.sv
// Directed and randomized bench for cplx_alu_sched against a plain-arithmetic reference model.
module tb_cplx_alu_sched;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [1:0]         op = 2'b00;
    logic               is_complex = 1'b0;
    logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic               in_ready, out_valid, out_err;
    logic [31:0]        y_re, y_im;

    int errors = 0;
    int checks = 0;

    cplx_alu_sched #(.W(16), .RW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_complex(is_complex),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_re(y_re), .y_im(y_im), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: complex/real arithmetic in wide integers, truncated to 32 bits.
    function automatic void model(input logic [1:0] o, input logic cx,
                                  input logic signed [15:0] ar, ai, br, bi,
                                  output logic [31:0] re, output logic [31:0] im,
                                  output logic err, output int lat);
        longint r, i;
        r = 0; i = 0; err = 1'b0; lat = 1;
        case (o)
            2'b00: begin r = longint'(ar) + longint'(br); if (cx) i = longint'(ai) + longint'(bi); end
            2'b01: begin r = longint'(ar) - longint'(br); if (cx) i = longint'(ai) - longint'(bi); end
            2'b10: begin
                r = longint'(ar) * longint'(br);
                if (cx) begin
                    r = r - longint'(ai) * longint'(bi);
                    i = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
                    lat = 4;
                end
            end
            default: err = 1'b1;
        endcase
        re = r[31:0];
        im = i[31:0];
    endfunction

    task automatic drive(input logic [1:0] o, input logic cx,
                         input logic signed [15:0] ar, ai, br, bi);
        op = o; is_complex = cx; a_re = ar; a_im = ai; b_re = br; b_im = bi;
    endtask

    task automatic scramble;
        op = 2'($urandom); is_complex = 1'($urandom);
        a_re = 16'($urandom); a_im = 16'($urandom); b_re = 16'($urandom); b_im = 16'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic cx,
                          input logic signed [15:0] ar, ai, br, bi,
                          input logic [31:0] ere, input logic [31:0] eim,
                          input logic eerr, input int elat);
        int cnt;
        drive(o, cx, ar, ai, br, bi);
        in_valid = 1'b1;
        out_ready = 1'b1;
        check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        scramble();
        cnt = 0;
        do begin
            check({tag, "_nooverlap"}, 32'(in_ready & out_valid), 32'd0);
            tick;
            cnt++;
        end while (!out_valid && cnt < 10);
        check({tag, "_lat"}, 32'(cnt), 32'(elat));
        check({tag, "_yre"}, y_re, ere);
        check({tag, "_yim"}, y_im, eim);
        check({tag, "_err"}, 32'(out_err), 32'(eerr));
        tick;
        check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdyback"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        check({tag, "_ov"}, 32'(out_valid), 32'd0);
        check({tag, "_yre"}, y_re, 32'd0);
        check({tag, "_yim"}, y_im, 32'd0);
        check({tag, "_err"}, 32'(out_err), 32'd0);
    endtask

    task automatic no_result(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen = seen | out_valid;
        end
        check({tag, "_noresult"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] ere, eim, hold_re, hold_im;
        logic        eerr;
        int          elat, cnt;
        logic        rdy_seen;

        tick; tick;
        rst_n = 1'b1;
        check_reset_state("rst_init");

        run_op("cadd", 2'b00, 1'b1, 16'sd27, 16'sd43, 16'sd8, 16'sd15, 32'd35, 32'd58, 1'b0, 1);
        run_op("csub", 2'b01, 1'b1, 16'sd27, 16'sd43, 16'sd8, 16'sd15, 32'd19, 32'd28, 1'b0, 1);
        run_op("cmul1", 2'b10, 1'b1, 16'sd27, 16'sd43, 16'sd8, 16'sd15, 32'hFFFF_FE53, 32'd749, 1'b0, 4);
        run_op("cmul2", 2'b10, 1'b1, 16'sd7, 16'sd1, 16'sd3, 16'sd3, 32'd18, 32'd24, 1'b0, 4);
        run_op("rmul", 2'b10, 1'b0, 16'sd7, 16'sd5, 16'sd3, 16'sd9, 32'd21, 32'd0, 1'b0, 1);
        run_op("resv", 2'b11, 1'b1, 16'sd7, 16'sd1, 16'sd3, 16'sd3, 32'd0, 32'd0, 1'b1, 1);
        run_op("wrap", 2'b10, 1'b1, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768,
               32'd0, 32'h8000_0000, 1'b0, 4);
        run_op("radd_neg", 2'b00, 1'b0, -16'sd5, 16'sd100, -16'sd7, 16'sd100,
               32'hFFFF_FFF4, 32'd0, 1'b0, 1);

        // Reset while IDLE with a nonzero result held.
        run_op("pre_idle", 2'b00, 1'b1, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 32'd4, 32'd6, 1'b0, 1);
        rst_n = 1'b0; tick; rst_n = 1'b1;
        check_reset_state("rst_idle");

        // Reset during complex mul at step 2.
        run_op("pre_exec", 2'b00, 1'b1, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 32'd18, 32'd18, 1'b0, 1);
        drive(2'b10, 1'b1, 16'sd100, 16'sd200, 16'sd300, 16'sd400);
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick;
        rst_n = 1'b0; tick; rst_n = 1'b1;
        check_reset_state("rst_exec");
        no_result("rst_exec");

        // Reset while DONE is waiting on the consumer.
        drive(2'b00, 1'b1, 16'sd11, 16'sd12, 16'sd13, 16'sd14);
        in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 10) begin tick; cnt++; end
        check("rst_done_reached", 32'(out_valid), 32'd1);
        rst_n = 1'b0; tick; rst_n = 1'b1;
        check_reset_state("rst_done");
        out_ready = 1'b1;
        no_result("rst_done");

        // Back-pressure: result must hold while inputs churn.
        drive(2'b10, 1'b1, 16'sd27, 16'sd43, 16'sd8, 16'sd15);
        in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 10) begin tick; cnt++; end
        check("bp_valid", 32'(out_valid), 32'd1);
        hold_re = y_re; hold_im = y_im;
        check("bp_yre0", hold_re, 32'hFFFF_FE53);
        rdy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            scramble();
            tick;
            rdy_seen = rdy_seen | in_ready;
            check("bp_yre", y_re, hold_re);
            check("bp_yim", y_im, hold_im);
            check("bp_ov", 32'(out_valid), 32'd1);
        end
        check("bp_inrdy", 32'(rdy_seen), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        check("bp_release_ov", 32'(out_valid), 32'd0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]         ro;
            logic               rc;
            logic signed [15:0] rar, rai, rbr, rbi;
            ro = 2'($urandom); rc = 1'($urandom);
            rar = 16'($urandom); rai = 16'($urandom); rbr = 16'($urandom); rbi = 16'($urandom);
            model(ro, rc, rar, rai, rbr, rbi, ere, eim, eerr, elat);
            run_op($sformatf("rnd%0d", n), ro, rc, rar, rai, rbr, rbi, ere, eim, eerr, elat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
